mem_stage: RTL and testbench
============================

# mem_stage

Parametrised memory-access stage of the in-order RV pipeline, between EX and WB. It forwards ALU results, and drives a request/acknowledge data-memory port for loads and stores. Loads are lane-selected and sign- or zero-extended; stores produce lane-replicated write data and byte strobes. The stage stalls EX while a memory access is outstanding, flags misaligned or illegal accesses, and registers every result toward WB.

## Interface
- XLEN, 64: datapath width, 32 or 64.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  EX presents an instruction.
- ready_o  out  1  stage can accept; EX holds its inputs while valid_i && !ready_o.
- aluout_i  in  XLEN  load/store address, or data for the regfile.
- store_data_i  in  XLEN  rs2 value for stores.
- load_i, store_i  in  1 each  access type; never both high.
- funct3_i  in  3  access size and signedness (RISC-V encoding).
- rf_wen_i  in  1  register write enable.
- rf_rd_i  in  5  destination register.
- pc_i  in  64  instruction PC.
- exit_i  in  1  exit marker, passed through.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 for a store.
- dmem_addr_o  out  XLEN  address aligned down to XLEN/8.
- dmem_wdata_o  out  XLEN  store data.
- dmem_wstrb_o  out  XLEN/8  byte strobes; 0 for a load.
- dmem_ack_i  in  1  access complete; for a load, dmem_rdata_i is valid in the same cycle.
- dmem_rdata_i  in  XLEN  aligned read word.
- wb_valid_o  out  1  WB outputs are valid this cycle (one-cycle pulse).
- rf_wen_o  out  1  register write enable to WB.
- rf_rd_o  out  5  destination register to WB.
- rf_wdata_o  out  XLEN  write data to WB.
- pc_o  out  64  PC to WB.
- exit_o  out  1  exit marker to WB.
- misalign_o  out  1  access was misaligned or illegal; valid with wb_valid_o.

## Operation
- FSM has two states, IDLE and WAIT. ready_o = (state == IDLE).
- Accept happens when valid_i && ready_o. On accept, the stage latches aluout_i, store_data_i, funct3_i, rf_wen_i, rf_rd_i, pc_i, exit_i, load_i and store_i.
- Non-memory op: registered to WB on the next edge.
  - rf_wdata_o = aluout_i.
  - rf_wen_o = rf_wen_i.
  - State stays IDLE.
- Memory op, aligned and legal: go to WAIT.
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o and dmem_wstrb_o are registered and held stable until the ack.
  - On dmem_ack_i in WAIT: return to IDLE and register the WB outputs.
- Misalignment rules:
  - Halfword is misaligned if addr[0] != 0.
  - Word is misaligned if addr[1:0] != 0.
  - Doubleword is misaligned if addr[2:0] != 0.
- Illegal encodings:
  - funct3 111, or funct3 011/110 with XLEN=32, on any memory op.
  - funct3 011/100/101/110 on a store.
- Misaligned or illegal op: no request is issued. WB outputs register on the next edge with misalign_o=1 and rf_wen_o=0.
- Load lane select: byte offset o = addr[log2(XLEN/8)-1:0]; the loaded value is dmem_rdata_i >> (8*o).
- Load extension:
  - LB/LH/LW/LD (funct3 000/001/010/011) sign-extend to XLEN.
  - LBU/LHU/LWU (funct3 100/101/110) zero-extend to XLEN.
  - rf_wen_o = rf_wen_i.
- Store data: dmem_wdata_o replicates the low 8/16/32/64 bits of store_data_i across all lanes.
- Store strobe: dmem_wstrb_o = size mask << o, with size mask 1, 3, 0xF or 0xFF.
- Stores force rf_wen_o = 0.
- dmem_ack_i is ignored in IDLE.

## Timing
- Reset values (asynchronous on rst_n low): state IDLE, and every output 0, except ready_o = 1.
- An outstanding request is dropped immediately on reset. The latched instruction is lost and produces no wb_valid_o.
- Latencies, for an op accepted at cycle T:
  - Non-memory op: wb_valid_o at T+1.
  - Misaligned or illegal op: wb_valid_o at T+1.
  - Memory op: dmem_req_o high from T+1. With the ack in cycle T+k (k ≥ 1), dmem_req_o drops and wb_valid_o is high at T+k+1.
- ready_o rises at T+k+1, and a new instruction may be accepted in that same cycle.
- Back-to-back non-memory ops sustain one per cycle.
- wb_valid_o stays high for exactly one cycle per accepted instruction. All WB outputs hold their values until the next wb_valid_o.
- rst_n deasserted mid-cycle: normal operation resumes from the next rising edge.

## Test plan
- Reset: assert rst_n=0 while in WAIT → dmem_req_o=0, ready_o=1, wb_valid_o=0 immediately; no WB pulse after release.
- ALU passthrough: 3 consecutive ops with aluout 0x1, 0x2, 0x3, rd 5/6/7 → wb_valid_o on 3 consecutive cycles with matching rf_wdata_o/rf_rd_o; ready_o stays 1.
- Load extension (XLEN=64), rdata=0x8877665544332211:
  - LB addr 0x1007 → rf_wdata_o = 0xFFFFFFFFFFFFFF88.
  - LBU addr 0x1007 → 0x88.
  - LH addr 0x1002 → 0x4433.
  - LWU addr 0x1004 → 0x88776655.
- Store with 3-cycle ack delay, SH of 0xABCD at addr 0x2006:
  - dmem_wdata_o = 0xABCDABCDABCDABCD, dmem_wstrb_o = 0xC0, dmem_addr_o = 0x2000.
  - Request held 3 cycles; ready_o = 0 throughout.
  - wb_valid_o with rf_wen_o = 0 one cycle after the ack.
- Misaligned LW at 0x3002 → no dmem_req_o; misalign_o=1 and rf_wen_o=0 at T+1.
- Spurious dmem_ack_i while IDLE → no state change, no wb_valid_o.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: forwards ALU results, runs a req/ack data-memory
// port for loads and stores, and registers every result toward WB.
module mem_stage #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [XLEN-1:0]   aluout_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic              load_i,
   input  logic              store_i,
   input  logic [2:0]        funct3_i,
   input  logic              rf_wen_i,
   input  logic [4:0]        rf_rd_i,
   input  logic [63:0]       pc_i,
   input  logic              exit_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   output logic [XLEN/8-1:0] dmem_wstrb_o,
   input  logic              dmem_ack_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic              wb_valid_o,
   output logic              rf_wen_o,
   output logic [4:0]        rf_rd_o,
   output logic [XLEN-1:0]   rf_wdata_o,
   output logic [63:0]       pc_o,
   output logic              exit_o,
   output logic              misalign_o
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]     wstrb_q, wstrb_d;
   logic              wb_valid_q, wb_valid_d;
   logic              rf_wen_q, rf_wen_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic [63:0]       pc_q, pc_d;
   logic              exit_q, exit_d;
   logic              misalign_q, misalign_d;
   logic              is_load_q, is_load_d;
   logic              lat_wen_q, lat_wen_d;
   logic [4:0]        lat_rd_q, lat_rd_d;
   logic [63:0]       lat_pc_q, lat_pc_d;
   logic              lat_exit_q, lat_exit_d;
   logic [2:0]        lat_f3_q, lat_f3_d;
   logic [OW-1:0]     lat_off_q, lat_off_d;

   // Decode of the instruction presented by EX
   logic [OW-1:0]   off_in;
   logic [3:0]      size_bytes;
   logic [2:0]      lane_mask;
   logic            misaligned;
   logic            illegal;
   logic [15:0]     strb_wide;
   logic [XLEN-1:0] st_rep;

   assign off_in     = aluout_i[OW-1:0];
   assign size_bytes = 4'd1 << funct3_i[1:0];
   assign lane_mask  = 3'(size_bytes - 4'd1);
   assign misaligned = |(off_in & OW'(lane_mask));
   assign illegal    = (funct3_i == 3'b111)
                    || ((XLEN == 32) && (funct3_i == 3'b011 || funct3_i == 3'b110))
                    || (store_i && (funct3_i == 3'b011 || funct3_i[2]));
   assign strb_wide  = ((16'd1 << size_bytes) - 16'd1) << off_in;

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign st_rep[8*gi +: 8] = store_data_i[8*(gi & int'(lane_mask)) +: 8];
   end

   // Load path: shift the addressed lane down, then extend from the top bit of the access size
   logic [XLEN-1:0] ld_shift, ld_mask, ld_top, ld_val;
   logic [6:0]      ld_bits;
   logic            ld_neg;

   assign ld_shift = dmem_rdata_i >> {lat_off_q, 3'b000};
   assign ld_bits  = 7'd8 << lat_f3_q[1:0];
   assign ld_mask  = ~({XLEN{1'b1}} << ld_bits);
   assign ld_top   = ld_mask ^ (ld_mask >> 1);
   assign ld_neg   = ~lat_f3_q[2] & (|(ld_shift & ld_top));
   assign ld_val   = ld_neg ? (ld_shift | ~ld_mask) : (ld_shift & ld_mask);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wb_valid_d = 1'b0;
      rf_wen_d   = rf_wen_q;
      rd_d       = rd_q;
      rf_wdata_d = rf_wdata_q;
      pc_d       = pc_q;
      exit_d     = exit_q;
      misalign_d = misalign_q;
      is_load_d  = is_load_q;
      lat_wen_d  = lat_wen_q;
      lat_rd_d   = lat_rd_q;
      lat_pc_d   = lat_pc_q;
      lat_exit_d = lat_exit_q;
      lat_f3_d   = lat_f3_q;
      lat_off_d  = lat_off_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (!(load_i || store_i) || misaligned || illegal) begin
                  wb_valid_d = 1'b1;
                  rf_wen_d   = rf_wen_i && !(load_i || store_i);
                  rd_d       = rf_rd_i;
                  rf_wdata_d = aluout_i;
                  pc_d       = pc_i;
                  exit_d     = exit_i;
                  misalign_d = load_i || store_i;
               end else begin
                  state_d    = WAIT;
                  req_d      = 1'b1;
                  we_d       = store_i;
                  addr_d     = {aluout_i[XLEN-1:OW], {OW{1'b0}}};
                  wdata_d    = store_i ? st_rep : '0;
                  wstrb_d    = store_i ? strb_wide[NB-1:0] : '0;
                  is_load_d  = load_i;
                  lat_wen_d  = rf_wen_i;
                  lat_rd_d   = rf_rd_i;
                  lat_pc_d   = pc_i;
                  lat_exit_d = exit_i;
                  lat_f3_d   = funct3_i;
                  lat_off_d  = off_in;
               end
            end
         end
         WAIT: begin
            if (dmem_ack_i) begin
               state_d    = IDLE;
               req_d      = 1'b0;
               we_d       = 1'b0;
               wstrb_d    = '0;
               wb_valid_d = 1'b1;
               rf_wen_d   = is_load_q && lat_wen_q;
               rd_d       = lat_rd_q;
               rf_wdata_d = is_load_q ? ld_val : '0;
               pc_d       = lat_pc_q;
               exit_d     = lat_exit_q;
               misalign_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wb_valid_q <= 1'b0;
         rf_wen_q   <= 1'b0;
         rd_q       <= '0;
         rf_wdata_q <= '0;
         pc_q       <= '0;
         exit_q     <= 1'b0;
         misalign_q <= 1'b0;
         is_load_q  <= 1'b0;
         lat_wen_q  <= 1'b0;
         lat_rd_q   <= '0;
         lat_pc_q   <= '0;
         lat_exit_q <= 1'b0;
         lat_f3_q   <= '0;
         lat_off_q  <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wb_valid_q <= wb_valid_d;
         rf_wen_q   <= rf_wen_d;
         rd_q       <= rd_d;
         rf_wdata_q <= rf_wdata_d;
         pc_q       <= pc_d;
         exit_q     <= exit_d;
         misalign_q <= misalign_d;
         is_load_q  <= is_load_d;
         lat_wen_q  <= lat_wen_d;
         lat_rd_q   <= lat_rd_d;
         lat_pc_q   <= lat_pc_d;
         lat_exit_q <= lat_exit_d;
         lat_f3_q   <= lat_f3_d;
         lat_off_q  <= lat_off_d;
      end
   end

   assign ready_o      = (state_q == IDLE);
   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign dmem_wstrb_o = wstrb_q;
   assign wb_valid_o   = wb_valid_q;
   assign rf_wen_o     = rf_wen_q;
   assign rf_rd_o      = rd_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign pc_o         = pc_q;
   assign exit_o       = exit_q;
   assign misalign_o   = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (XLEN=64): directed cases with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i, ready_o;
   logic [63:0] aluout_i, store_data_i;
   logic        load_i, store_i;
   logic [2:0]  funct3_i;
   logic        rf_wen_i;
   logic [4:0]  rf_rd_i;
   logic [63:0] pc_i;
   logic        exit_i;
   logic        dmem_req_o, dmem_we_o;
   logic [63:0] dmem_addr_o, dmem_wdata_o;
   logic [7:0]  dmem_wstrb_o;
   logic        dmem_ack_i;
   logic [63:0] dmem_rdata_i;
   logic        wb_valid_o, rf_wen_o;
   logic [4:0]  rf_rd_o;
   logic [63:0] rf_wdata_o, pc_o;
   logic        exit_o, misalign_o;

   always #5 clk = ~clk;

   mem_stage #(.XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .aluout_i(aluout_i), .store_data_i(store_data_i), .load_i(load_i), .store_i(store_i),
      .funct3_i(funct3_i), .rf_wen_i(rf_wen_i), .rf_rd_i(rf_rd_i), .pc_i(pc_i), .exit_i(exit_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_ack_i(dmem_ack_i),
      .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .rf_wen_o(rf_wen_o),
      .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o), .pc_o(pc_o), .exit_o(exit_o),
      .misalign_o(misalign_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic bad_op(input logic st, input logic [2:0] f3, input logic [63:0] a);
      logic [63:0] size;
      size = 64'd1 << f3[1:0];
      return (f3 == 3'd7) || (st && (f3 == 3'd3 || f3 >= 3'd4)) || ((a % size) != 64'd0);
   endfunction

   function automatic logic [63:0] load_result(input logic [63:0] rd, input logic [2:0] f3,
                                               input logic [63:0] a);
      logic [63:0] v;
      v = rd >> (8 * (a % 8));
      case (f3)
         3'd0:    return {{56{v[7]}}, v[7:0]};
         3'd1:    return {{48{v[15]}}, v[15:0]};
         3'd2:    return {{32{v[31]}}, v[31:0]};
         3'd4:    return {56'd0, v[7:0]};
         3'd5:    return {48'd0, v[15:0]};
         3'd6:    return {32'd0, v[31:0]};
         default: return v;
      endcase
   endfunction

   function automatic logic [63:0] store_rep(input logic [63:0] d, input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return {8{d[7:0]}};
         2'd1:    return {4{d[15:0]}};
         2'd2:    return {2{d[31:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [7:0] store_strb(input logic [2:0] f3, input logic [63:0] a);
      int bytes;
      bytes = 1 << f3[1:0];
      return 8'(((1 << bytes) - 1) << (a % 8));
   endfunction

   logic        m_busy, m_we, m_wbv, m_wen, m_exit, m_mis, m_wchk;
   logic [63:0] m_addr, m_dwdata, m_wdata, m_pc;
   logic [7:0]  m_wstrb;
   logic [4:0]  m_rd;
   logic        l_ld, l_wen, l_exit;
   logic [2:0]  l_f3;
   logic [63:0] l_addr, l_pc;
   logic [4:0]  l_rd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_we <= 1'b0; m_wbv <= 1'b0; m_wen <= 1'b0; m_exit <= 1'b0;
         m_mis <= 1'b0; m_wchk <= 1'b1; m_addr <= '0; m_dwdata <= '0; m_wdata <= '0;
         m_pc <= '0; m_wstrb <= '0; m_rd <= '0;
         l_ld <= 1'b0; l_wen <= 1'b0; l_exit <= 1'b0; l_f3 <= '0; l_addr <= '0;
         l_pc <= '0; l_rd <= '0;
      end else begin
         m_wbv <= 1'b0;
         if (!m_busy && valid_i) begin
            if (!(load_i || store_i) || bad_op(store_i, funct3_i, aluout_i)) begin
               m_wbv   <= 1'b1;
               m_wen   <= rf_wen_i && !(load_i || store_i);
               m_rd    <= rf_rd_i;
               m_wdata <= aluout_i;
               m_pc    <= pc_i;
               m_exit  <= exit_i;
               m_mis   <= load_i || store_i;
               m_wchk  <= !(load_i || store_i);
            end else begin
               m_busy   <= 1'b1;
               m_we     <= store_i;
               m_addr   <= aluout_i & ~64'd7;
               m_dwdata <= store_i ? store_rep(store_data_i, funct3_i) : 64'd0;
               m_wstrb  <= store_i ? store_strb(funct3_i, aluout_i) : 8'd0;
               l_ld <= load_i; l_wen <= rf_wen_i; l_exit <= exit_i; l_f3 <= funct3_i;
               l_addr <= aluout_i; l_pc <= pc_i; l_rd <= rf_rd_i;
            end
         end else if (m_busy && dmem_ack_i) begin
            m_busy  <= 1'b0;
            m_wbv   <= 1'b1;
            m_wen   <= l_ld && l_wen;
            m_rd    <= l_rd;
            m_wdata <= load_result(dmem_rdata_i, l_f3, l_addr);
            m_pc    <= l_pc;
            m_exit  <= l_exit;
            m_mis   <= 1'b0;
            m_wchk  <= l_ld;
         end
      end
   end

   always @(negedge clk) begin
      chk("ready", {63'd0, ready_o}, {63'd0, !m_busy});
      chk("req", {63'd0, dmem_req_o}, {63'd0, m_busy});
      if (m_busy) begin
         chk("we", {63'd0, dmem_we_o}, {63'd0, m_we});
         chk("addr", dmem_addr_o, m_addr);
         chk("dwdata", dmem_wdata_o, m_dwdata);
         chk("wstrb", {56'd0, dmem_wstrb_o}, {56'd0, m_wstrb});
      end
      chk("wb_valid", {63'd0, wb_valid_o}, {63'd0, m_wbv});
      if (m_wbv) begin
         chk("rf_wen", {63'd0, rf_wen_o}, {63'd0, m_wen});
         chk("rf_rd", {59'd0, rf_rd_o}, {59'd0, m_rd});
         chk("pc", pc_o, m_pc);
         chk("exit", {63'd0, exit_o}, {63'd0, m_exit});
         chk("misalign", {63'd0, misalign_o}, {63'd0, m_mis});
         if (m_wchk) chk("rf_wdata", rf_wdata_o, m_wdata);
      end
   end

   // ---------------- stimulus ----------------
   int          r_lat, r_reqcyc, r_rdylow;
   logic        r_seen, r_wen, r_mis;
   logic [63:0] r_wdata, r_addr, r_dwdata;
   logic [7:0]  r_wstrb;

   // Presents one instruction (called just after a rising edge), waits for acceptance, then
   // acks the request `delay` cycles after acceptance and captures the WB result.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sd, input logic wen,
                        input logic [4:0] rd, input int delay, input logic [63:0] rdata);
      logic acc;
      acc = 1'b0;
      valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3; aluout_i = addr;
      store_data_i = sd; rf_wen_i = wen; rf_rd_i = rd;
      pc_i = {$urandom, $urandom}; exit_i = 1'($urandom_range(0, 1));
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk) acc = ready_o;
         @(posedge clk) #1;
      end
      chk("accept_seen", {63'd0, acc}, 64'd1);
      valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
      r_seen = 1'b0; r_reqcyc = 0; r_rdylow = 0; r_lat = 0;
      for (int c = 1; c <= 60 && !r_seen; c++) begin
         dmem_ack_i   = (c == delay);
         dmem_rdata_i = (c == delay) ? rdata : {$urandom, $urandom};
         @(negedge clk);
         if (c == 1) begin
            r_addr = dmem_addr_o; r_dwdata = dmem_wdata_o; r_wstrb = dmem_wstrb_o;
         end
         if (dmem_req_o) r_reqcyc++;
         if (!ready_o) r_rdylow++;
         if (wb_valid_o) begin
            r_seen = 1'b1; r_lat = c; r_wdata = rf_wdata_o; r_wen = rf_wen_o;
            r_mis = misalign_o;
         end
         @(posedge clk) #1;
      end
      dmem_ack_i = 1'b0;
      chk("wb_seen", {63'd0, r_seen}, 64'd1);
      $display("txn ld=%0b st=%0b f3=%0d addr=%h lat=%0d wdata=%h wen=%0b mis=%0b",
               ld, st, f3, addr, r_lat, r_wdata, r_wen, r_mis);
   endtask

   localparam logic [63:0] RDATA = 64'h8877665544332211;

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; aluout_i = '0; store_data_i = '0; load_i = 1'b0;
      store_i = 1'b0; funct3_i = '0; rf_wen_i = 1'b0; rf_rd_i = '0; pc_i = '0; exit_i = 1'b0;
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      #7;
      chk("reset_ready", {63'd0, ready_o}, 64'd1);
      chk("reset_req", {63'd0, dmem_req_o}, 64'd0);
      chk("reset_wb_valid", {63'd0, wb_valid_o}, 64'd0);
      chk("reset_rf_wdata", rf_wdata_o, 64'd0);
      #15 rst_n = 1'b1;
      @(posedge clk) #1;

      // ALU passthrough, back to back
      valid_i = 1'b1; rf_wen_i = 1'b1; aluout_i = 64'h1; rf_rd_i = 5'd5; pc_i = 64'h100;
      @(negedge clk) chk("b2b_ready0", {63'd0, ready_o}, 64'd1);
      @(posedge clk) #1; aluout_i = 64'h2; rf_rd_i = 5'd6;
      @(negedge clk);
      chk("b2b_wb1", {63'd0, wb_valid_o}, 64'd1); chk("b2b_rd1", {59'd0, rf_rd_o}, 64'd5);
      chk("b2b_wd1", rf_wdata_o, 64'h1); chk("b2b_ready1", {63'd0, ready_o}, 64'd1);
      @(posedge clk) #1; aluout_i = 64'h3; rf_rd_i = 5'd7;
      @(negedge clk);
      chk("b2b_wb2", {63'd0, wb_valid_o}, 64'd1); chk("b2b_rd2", {59'd0, rf_rd_o}, 64'd6);
      chk("b2b_wd2", rf_wdata_o, 64'h2); chk("b2b_ready2", {63'd0, ready_o}, 64'd1);
      @(posedge clk) #1; valid_i = 1'b0;
      @(negedge clk);
      chk("b2b_wb3", {63'd0, wb_valid_o}, 64'd1); chk("b2b_rd3", {59'd0, rf_rd_o}, 64'd7);
      chk("b2b_wd3", rf_wdata_o, 64'h3);
      @(posedge clk) #1;
      @(negedge clk) chk("b2b_wb_end", {63'd0, wb_valid_o}, 64'd0);
      @(posedge clk) #1;

      // Load lane select and extension
      issue(1, 0, 3'd0, 64'h1007, 0, 1, 5'd1, 1, RDATA);
      chk("lb", r_wdata, 64'hFFFFFFFFFFFFFF88); chk("lb_lat", 64'(r_lat), 64'd2);
      issue(1, 0, 3'd4, 64'h1007, 0, 1, 5'd2, 2, RDATA);
      chk("lbu", r_wdata, 64'h88); chk("lbu_lat", 64'(r_lat), 64'd3);
      issue(1, 0, 3'd1, 64'h1002, 0, 1, 5'd3, 1, RDATA);
      chk("lh", r_wdata, 64'h4433);
      issue(1, 0, 3'd6, 64'h1004, 0, 1, 5'd4, 1, RDATA);
      chk("lwu", r_wdata, 64'h88776655); chk("lwu_wen", {63'd0, r_wen}, 64'd1);

      // Store halfword with a three-cycle ack
      issue(0, 1, 3'd1, 64'h2006, 64'hABCD, 1, 5'd8, 3, 0);
      chk("sh_wdata", r_dwdata, 64'hABCDABCDABCDABCD);
      chk("sh_wstrb", {56'd0, r_wstrb}, 64'hC0);
      chk("sh_addr", r_addr, 64'h2000);
      chk("sh_req_cycles", 64'(r_reqcyc), 64'd3);
      chk("sh_ready_low", 64'(r_rdylow), 64'd3);
      chk("sh_lat", 64'(r_lat), 64'd4);
      chk("sh_wen", {63'd0, r_wen}, 64'd0);

      // Misaligned word load
      issue(1, 0, 3'd2, 64'h3002, 0, 1, 5'd9, 1, RDATA);
      chk("mis_req", 64'(r_reqcyc), 64'd0); chk("mis_flag", {63'd0, r_mis}, 64'd1);
      chk("mis_wen", {63'd0, r_wen}, 64'd0); chk("mis_lat", 64'(r_lat), 64'd1);

      // Spurious ack while idle
      dmem_ack_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("spur_wb", {63'd0, wb_valid_o}, 64'd0);
         chk("spur_ready", {63'd0, ready_o}, 64'd1);
         @(posedge clk) #1;
      end
      dmem_ack_i = 1'b0;

      // Reset while waiting for an ack
      valid_i = 1'b1; load_i = 1'b1; funct3_i = 3'd2; aluout_i = 64'h4000; rf_wen_i = 1'b1;
      rf_rd_i = 5'd10;
      @(negedge clk) chk("rst_pre_ready", {63'd0, ready_o}, 64'd1);
      @(posedge clk) #1; valid_i = 1'b0; load_i = 1'b0;
      @(negedge clk) chk("rst_req_held", {63'd0, dmem_req_o}, 64'd1);
      @(posedge clk) #3 rst_n = 1'b0;
      #1;
      chk("rst_req", {63'd0, dmem_req_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd1);
      chk("rst_wb", {63'd0, wb_valid_o}, 64'd0);
      @(posedge clk) #3 rst_n = 1'b1;
      repeat (3) @(negedge clk) chk("rst_no_wb", {63'd0, wb_valid_o}, 64'd0);
      @(posedge clk) #1;

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         int          kind;
         logic [2:0]  f3;
         logic [63:0] a;
         kind = $urandom_range(0, 2);
         f3   = 3'($urandom_range(0, 7));
         a    = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
         issue(kind == 1, kind == 2, f3, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom_range(1, 4), {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) begin
            dmem_ack_i = 1'($urandom_range(0, 1));
            @(posedge clk) #1;
         end
         dmem_ack_i = 1'b0;
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
